// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//
// Shared definitions for the nPower control-path pipeline chain.
//
// Control bundle layout, MSB to LSB:
//   {RegWrite, ALUSrc, Branch, ALUop[ALUOP_W-1:0], MemWrite, MemRead, MemtoReg}
// The low fields sit at fixed positions. The fields above ALUop move with
// ALUOP_W, so their positions come from small helper functions.
//
// Forwarding select encodings drive the EX operand muxes:
//   FWD_RF : operand comes from the register file
//   FWD_S2 : operand comes from stage 2
//   FWD_S1 : operand comes from stage 1 (youngest producer, wins ties)
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int M2R_BIT   = 0;
  localparam int MR_BIT    = 1;
  localparam int MW_BIT    = 2;
  localparam int ALUOP_LSB = 3;

  function automatic int ctrl_width(input int aluop_w);
    return 6 + aluop_w;
  endfunction

  function automatic int aluop_msb(input int aluop_w);
    return ALUOP_LSB + aluop_w - 1;
  endfunction

  function automatic int br_bit(input int aluop_w);
    return ALUOP_LSB + aluop_w;
  endfunction

  function automatic int alusrc_bit(input int aluop_w);
    return ALUOP_LSB + aluop_w + 1;
  endfunction

  function automatic int rw_bit(input int aluop_w);
    return ALUOP_LSB + aluop_w + 2;
  endfunction

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_S2 = 2'b01,
    FWD_S1 = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_stage
//
// One control-path pipeline register. It holds a valid bit, the control
// bundle, the PC and the destination register of a single instruction.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   hold_i              keep the current contents (whole-chain freeze)
//   bubble_i            load an empty slot: valid=0 and every field 0
//   squash_i            clear the valid bit of whatever ends up stored
//   valid_i, ctrl_i,
//   pc_i, rd_i          contents of the previous stage or the decode slot
//   valid_o, ctrl_o,
//   pc_o, rd_o          registered stage contents
//
// Priority: hold > bubble > load. Squash combines with both hold and load.
// ---------------------------------------------------------------------------
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W = 9,
  parameter int PC_W   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic              squash_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [REG_AW-1:0] rd_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [REG_AW-1:0] rd_q,    rd_d;

  // Next-state selection for the stage.
  // A frozen stage keeps its data, but a flush can still kill it.
  // A bubble clears the control bundle as well as the valid bit. This stops a
  // slot that was never filled from enabling a register-file or memory write.
  // A squashed load keeps its fields and only drops the valid bit.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    if (hold_i) begin
      if (squash_i) begin
        valid_d = 1'b0;
      end
    end else if (bubble_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      pc_d    = '0;
      rd_d    = '0;
    end else begin
      valid_d = valid_i & ~squash_i;
      ctrl_d  = ctrl_i;
      pc_d    = pc_i;
      rd_d    = rd_i;
    end
  end

  // Stage register. Reset empties the slot immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign pc_o    = pc_q;
  assign rd_o    = rd_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_chain
//
// Control-path pipeline for the nPower core. It carries each decoded
// instruction's control bundle, PC and destination register from decode
// through DEPTH stage registers. Stage 0 is ID/EX and stage DEPTH-1 is MEM/WB.
// The chain also raises the decode stall on data hazards, applies branch
// flushes and, optionally, produces the EX operand forwarding selects.
//
// Build option:
//   PIPE_CTRL_FWD_EN  When defined, stage 0 also keeps ra/rb, fwd_a/fwd_b are
//                     driven, and only a load-use case stalls decode. When
//                     undefined, fwd_a/fwd_b are tied to 0 and decode stalls
//                     on any RAW hazard against stages 0..DEPTH-2.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   in_valid, in_ctrl,
//   in_pc, in_rd,
//   in_ra, in_rb          decode slot contents
//   ext_stall             freeze the whole chain (memory wait)
//   flush                 branch resolved taken
//   stall_out             decode must hold (combinational)
//   st_valid              per-stage valid bits
//   st_ctrl/st_pc/st_rd   stage k at [k*W +: W]
//   fwd_a, fwd_b          EX operand selects (fwd_sel_e encodings)
//   stall_cnt             saturating count of counted decode-stall cycles
// ---------------------------------------------------------------------------
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter  int DEPTH       = 3,
  parameter  int PC_W        = 64,
  parameter  int ALUOP_W     = 3,
  parameter  int REG_AW      = 5,
  parameter  int FLUSH_DEPTH = 1,
  localparam int CTRL_W      = 6 + ALUOP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic [REG_AW-1:0]        in_ra,
  input  logic [REG_AW-1:0]        in_rb,
  input  logic                     ext_stall,
  input  logic                     flush,
  output logic                     stall_out,
  output logic [DEPTH-1:0]         st_valid,
  output logic [DEPTH*CTRL_W-1:0]  st_ctrl,
  output logic [DEPTH*PC_W-1:0]    st_pc,
  output logic [DEPTH*REG_AW-1:0]  st_rd,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic [31:0]              stall_cnt
);

  localparam int RW_POS = rw_bit(ALUOP_W);

  logic [DEPTH-1:0]  valid_w;
  logic [CTRL_W-1:0] ctrl_w [DEPTH];
  logic [PC_W-1:0]   pc_w   [DEPTH];
  logic [REG_AW-1:0] rd_w   [DEPTH];

  logic        hazard;
  logic        bubble0;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stage chain. Stage 0 takes the decode slot and stage k takes stage k-1.
  // ext_stall freezes every stage. A flush squashes the youngest FLUSH_DEPTH
  // stages. Only stage 0 can take a hazard bubble, because the older stages
  // keep draining while decode waits.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam bit SQUASH_EN = (k < FLUSH_DEPTH);
    localparam bit IS_HEAD   = (k == 0);

    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [PC_W-1:0]   pc_in;
    logic [REG_AW-1:0] rd_in;
    logic              bubble_k;
    logic              squash_k;

    if (k == 0) begin : g_head
      assign valid_in = in_valid;
      assign ctrl_in  = in_ctrl;
      assign pc_in    = in_pc;
      assign rd_in    = in_rd;
    end else begin : g_body
      assign valid_in = valid_w[k-1];
      assign ctrl_in  = ctrl_w[k-1];
      assign pc_in    = pc_w[k-1];
      assign rd_in    = rd_w[k-1];
    end

    assign bubble_k = bubble0 & IS_HEAD;
    assign squash_k = flush & SQUASH_EN;

    pipe_ctrl_stage #(
      .CTRL_W (CTRL_W),
      .PC_W   (PC_W),
      .REG_AW (REG_AW)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .hold_i   (ext_stall),
      .bubble_i (bubble_k),
      .squash_i (squash_k),
      .valid_i  (valid_in),
      .ctrl_i   (ctrl_in),
      .pc_i     (pc_in),
      .rd_i     (rd_in),
      .valid_o  (valid_w[k]),
      .ctrl_o   (ctrl_w[k]),
      .pc_o     (pc_w[k]),
      .rd_o     (rd_w[k])
    );

    assign st_ctrl[k*CTRL_W +: CTRL_W] = ctrl_w[k];
    assign st_pc[k*PC_W +: PC_W]       = pc_w[k];
    assign st_rd[k*REG_AW +: REG_AW]   = rd_w[k];
  end

  assign st_valid = valid_w;

`ifdef PIPE_CTRL_FWD_EN
  logic [REG_AW-1:0] ra0_q, ra0_d;
  logic [REG_AW-1:0] rb0_q, rb0_d;
  fwd_sel_e          fwd_a_sel, fwd_b_sel;
  logic              s1_wr, s2_wr;

  // With forwarding, only a load in ID/EX stalls a dependent instruction.
  // The loaded value is not ready until after MEM.
  always_comb begin
    hazard = 1'b0;
    if (valid_w[0] && ctrl_w[0][MR_BIT] &&
        (rd_w[0] == in_ra || rd_w[0] == in_rb)) begin
      hazard = 1'b1;
    end
  end

  // ra/rb move with stage 0 so that the forwarding compare sees the operands
  // of the instruction that is now in EX. A bubble zeroes them.
  always_comb begin
    ra0_d = ra0_q;
    rb0_d = rb0_q;
    if (!ext_stall) begin
      if (bubble0) begin
        ra0_d = '0;
        rb0_d = '0;
      end else begin
        ra0_d = in_ra;
        rb0_d = in_rb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra0_q <= '0;
      rb0_q <= '0;
    end else begin
      ra0_q <= ra0_d;
      rb0_q <= rb0_d;
    end
  end

  assign s1_wr = valid_w[1] & ctrl_w[1][RW_POS];
  assign s2_wr = valid_w[2] & ctrl_w[2][RW_POS];

  // Operand select for the instruction in EX. Stage 1 holds the youngest
  // result, so it takes priority when both older stages write the register.
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (valid_w[0]) begin
      if (s1_wr && rd_w[1] == ra0_q) begin
        fwd_a_sel = FWD_S1;
      end else if (s2_wr && rd_w[2] == ra0_q) begin
        fwd_a_sel = FWD_S2;
      end
      if (s1_wr && rd_w[1] == rb0_q) begin
        fwd_b_sel = FWD_S1;
      end else if (s2_wr && rd_w[2] == rb0_q) begin
        fwd_b_sel = FWD_S2;
      end
    end
  end

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;
`else
  // Without forwarding, any pending writer that has not yet reached MEM/WB
  // blocks a reader. The last stage is left out because the register file
  // writes in the first half of the cycle and reads in the second.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (valid_w[k] && ctrl_w[k][RW_POS] &&
          (rd_w[k] == in_ra || rd_w[k] == in_rb)) begin
        hazard = 1'b1;
      end
    end
  end

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // A taken branch throws away the decode slot anyway, so the chain never
  // stalls on it. The bubble goes in only when the chain actually moves.
  assign stall_out = in_valid & hazard & ~flush;
  assign bubble0   = stall_out & ~ext_stall;

  // Count the stall cycles that really cost a decode slot. These are the
  // same cycles in which stage 0 takes a bubble. The count stops at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bubble0 && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Testbench for pipe_ctrl_chain with DEPTH=3 and FLUSH_DEPTH=2.
// A reference model of the pipeline occupancy tracks the DUT every cycle.
// A vector table covers the directed scenarios. Hand sequences cover flush,
// ext_stall and a reset in the middle of a stream. Random traffic follows.
module tb_pipe_ctrl_chain;

  localparam int DEPTH       = 3;
  localparam int PC_W        = 64;
  localparam int ALUOP_W     = 3;
  localparam int REG_AW      = 5;
  localparam int FLUSH_DEPTH = 2;
  localparam int CTRL_W      = 6 + ALUOP_W;
  localparam int RW          = CTRL_W - 1;
  localparam int MR          = 1;

  localparam logic [CTRL_W-1:0] ALU = 9'h108;
  localparam logic [CTRL_W-1:0] LD  = 9'h183;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    inValid;
  logic [CTRL_W-1:0]       inCtrl;
  logic [PC_W-1:0]         inPc;
  logic [REG_AW-1:0]       inRd, inRa, inRb;
  logic                    extStall, flush;
  logic                    stallOut;
  logic [DEPTH-1:0]        stValid;
  logic [DEPTH*CTRL_W-1:0] stCtrl;
  logic [DEPTH*PC_W-1:0]   stPc;
  logic [DEPTH*REG_AW-1:0] stRd;
  logic [1:0]              fwdA, fwdB;
  logic [31:0]             stallCnt;

  int testsRun    = 0;
  int testsFailed = 0;

  pipe_ctrl_chain #(
    .DEPTH(DEPTH), .PC_W(PC_W), .ALUOP_W(ALUOP_W),
    .REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ctrl(inCtrl),
    .in_pc(inPc), .in_rd(inRd), .in_ra(inRa), .in_rb(inRb),
    .ext_stall(extStall), .flush(flush), .stall_out(stallOut),
    .st_valid(stValid), .st_ctrl(stCtrl), .st_pc(stPc), .st_rd(stRd),
    .fwd_a(fwdA), .fwd_b(fwdB), .stall_cnt(stallCnt)
  );

  always #5 clk = ~clk;

  // Reference model: the contents of each pipeline slot, oldest last.
  typedef struct {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] rd, ra, rb;
  } slot_t;
  slot_t       pipe[DEPTH];
  logic [31:0] mCnt;

  function automatic slot_t emptySlot();
    slot_t s;
    s.v = 1'b0; s.c = '0; s.pc = '0; s.rd = '0; s.ra = '0; s.rb = '0;
    return s;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < DEPTH; k++) pipe[k] = emptySlot();
    mCnt = '0;
  endtask

  function automatic logic writes(input int k, input logic [REG_AW-1:0] r);
    return pipe[k].v && pipe[k].c[RW] && pipe[k].rd == r;
  endfunction

  function automatic logic modelStall();
    logic dep;
    dep = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
    dep = pipe[0].v && pipe[0].c[MR] && (pipe[0].rd == inRa || pipe[0].rd == inRb);
`else
    for (int k = 0; k < DEPTH - 1; k++)
      if (writes(k, inRa) || writes(k, inRb)) dep = 1'b1;
`endif
    return inValid && !flush && dep;
  endfunction

  function automatic logic [1:0] modelFwd(input logic [REG_AW-1:0] src);
`ifdef PIPE_CTRL_FWD_EN
    if (!pipe[0].v) return 2'b00;
    if (writes(1, src)) return 2'b10;
    if (writes(2, src)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic modelStep();
    logic st;
    slot_t nw;
    st = modelStall();
    if (!extStall) begin
      for (int k = DEPTH - 1; k > 0; k--) pipe[k] = pipe[k-1];
      if (st) begin
        pipe[0] = emptySlot();
      end else begin
        nw.v = inValid; nw.c = inCtrl; nw.pc = inPc;
        nw.rd = inRd; nw.ra = inRa; nw.rb = inRb;
        pipe[0] = nw;
      end
      if (st && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 32'd1;
    end
    if (flush)
      for (int k = 0; k < FLUSH_DEPTH; k++) pipe[k].v = 1'b0;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Compares the combinational outputs against the model before the edge.
  task automatic checkComb();
    check("stall_out", 64'(stallOut), 64'(modelStall()));
    check("fwd_a", 64'(fwdA), 64'(modelFwd(pipe[0].ra)));
    check("fwd_b", 64'(fwdB), 64'(modelFwd(pipe[0].rb)));
  endtask

  // Compares the registered state against the model.
  task automatic checkOutput();
    logic [DEPTH-1:0] ev;
    for (int k = 0; k < DEPTH; k++) ev[k] = pipe[k].v;
    check("st_valid", 64'(stValid), 64'(ev));
    check("stall_cnt", 64'(stallCnt), 64'(mCnt));
    for (int k = 0; k < DEPTH; k++) begin
      if (pipe[k].v) begin
        check($sformatf("st_ctrl%0d", k), 64'(stCtrl[k*CTRL_W +: CTRL_W]), 64'(pipe[k].c));
        check($sformatf("st_pc%0d", k), stPc[k*PC_W +: PC_W], pipe[k].pc);
        check($sformatf("st_rd%0d", k), 64'(stRd[k*REG_AW +: REG_AW]), 64'(pipe[k].rd));
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [PC_W-1:0] pc, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] ra, input logic [REG_AW-1:0] rb,
                               input logic ext, input logic fl);
    inValid = v; inCtrl = c; inPc = pc; inRd = rd; inRa = ra; inRb = rb;
    extStall = ext; flush = fl;
    #1;
    checkComb();
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                      input logic [PC_W-1:0] pc, input logic [REG_AW-1:0] rd,
                      input logic [REG_AW-1:0] ra, input logic [REG_AW-1:0] rb,
                      input logic ext, input logic fl);
    applyStimulus(v, c, pc, rd, ra, rb, ext, fl);
    clockEdge();
  endtask

  typedef struct {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] rd, ra, rb;
    logic              expStall;
    logic [1:0]        expFwdA;
    logic [DEPTH-1:0]  expValid;
    logic [31:0]       expCnt;
    logic              chkPc2;
    logic [PC_W-1:0]   expPc2;
    logic              chkBubble;
  } vec_t;
  vec_t vecs[$];

  task automatic addVec(input logic v, input logic [CTRL_W-1:0] c, input logic [PC_W-1:0] pc,
                        input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] ra,
                        input logic [REG_AW-1:0] rb, input logic es, input logic [1:0] efa,
                        input logic [DEPTH-1:0] ev, input logic [31:0] ec,
                        input logic cp, input logic [PC_W-1:0] ep, input logic cb);
    vec_t t;
    t.v = v; t.c = c; t.pc = pc; t.rd = rd; t.ra = ra; t.rb = rb;
    t.expStall = es; t.expFwdA = efa; t.expValid = ev; t.expCnt = ec;
    t.chkPc2 = cp; t.expPc2 = ep; t.chkBubble = cb;
    vecs.push_back(t);
  endtask

  task automatic addIdle(input logic [1:0] efa, input logic [DEPTH-1:0] ev, input logic [31:0] ec,
                         input logic cp, input logic [PC_W-1:0] ep);
    addVec(0, '0, '0, '0, '0, '0, 0, efa, ev, ec, cp, ep, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] savedCnt;

    // Four back-to-back ALU ops, then drain.
    addVec(1, ALU, 0,  10, 20, 21, 0, 0, 3'b001, 0, 0, 0,  0);
    addVec(1, ALU, 4,  11, 20, 21, 0, 0, 3'b011, 0, 0, 0,  0);
    addVec(1, ALU, 8,  12, 20, 21, 0, 0, 3'b111, 0, 1, 0,  0);
    addVec(1, ALU, 12, 13, 20, 21, 0, 0, 3'b111, 0, 1, 4,  0);
    addIdle(0, 3'b110, 0, 1, 8);
    addIdle(0, 3'b100, 0, 1, 12);
    addIdle(0, 3'b000, 0, 0, 0);
    // Load rd=5 followed by a reader of r5.
    addVec(1, LD,  16, 5, 20, 21, 0, 0, 3'b001, 0, 0, 0, 0);
    addVec(1, ALU, 20, 6, 5,  21, 1, 0, 3'b010, 1, 0, 0, 1);
`ifdef PIPE_CTRL_FWD_EN
    addVec(1, ALU, 20, 6, 5,  21, 0, 0, 3'b101, 1, 1, 16, 0);
    addIdle(2'b01, 3'b010, 1, 0, 0);
    addIdle(0, 3'b100, 1, 0, 0);
    addIdle(0, 3'b000, 1, 0, 0);
    addIdle(0, 3'b000, 1, 0, 0);
    // add rd=3 then add ra=3: forwarded from stage 1, no stall.
    addVec(1, ALU, 24, 3, 20, 21, 0, 0, 3'b001, 1, 0, 0, 0);
    addVec(1, ALU, 28, 7, 3,  21, 0, 0, 3'b011, 1, 0, 0, 0);
    addIdle(2'b10, 3'b110, 1, 0, 0);
    addIdle(0, 3'b100, 1, 0, 0);
    addIdle(0, 3'b000, 1, 0, 0);
    addIdle(0, 3'b000, 1, 0, 0);
    addIdle(0, 3'b000, 1, 0, 0);
`else
    addVec(1, ALU, 20, 6, 5,  21, 1, 0, 3'b100, 2, 1, 16, 0);
    addVec(1, ALU, 20, 6, 5,  21, 0, 0, 3'b001, 2, 0, 0,  0);
    addIdle(0, 3'b010, 2, 0, 0);
    addIdle(0, 3'b100, 2, 0, 0);
    addIdle(0, 3'b000, 2, 0, 0);
    // add rd=3 then add ra=3: stalls DEPTH-1 = 2 cycles.
    addVec(1, ALU, 24, 3, 20, 21, 0, 0, 3'b001, 2, 0, 0, 0);
    addVec(1, ALU, 28, 7, 3,  21, 1, 0, 3'b010, 3, 0, 0, 0);
    addVec(1, ALU, 28, 7, 3,  21, 1, 0, 3'b100, 4, 0, 0, 0);
    addVec(1, ALU, 28, 7, 3,  21, 0, 0, 3'b001, 4, 0, 0, 0);
    addIdle(0, 3'b010, 4, 0, 0);
    addIdle(0, 3'b100, 4, 0, 0);
    addIdle(0, 3'b000, 4, 0, 0);
`endif

    // Reset state.
    modelReset();
    reset = 1'b1;
    inValid = 0; inCtrl = '0; inPc = '0; inRd = '0; inRa = '0; inRb = '0;
    extStall = 0; flush = 0;
    #12;
    check("reset_valid", 64'(stValid), 0);
    check("reset_cnt", 64'(stallCnt), 0);
    check("reset_stall", 64'(stallOut), 0);
    check("reset_fwd", 64'({fwdA, fwdB}), 0);
    reset = 1'b0;

    // Table-driven directed scenarios.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].c, vecs[i].pc, vecs[i].rd, vecs[i].ra, vecs[i].rb, 0, 0);
      check($sformatf("vec%0d_stall", i), 64'(stallOut), 64'(vecs[i].expStall));
      check($sformatf("vec%0d_fwd_a", i), 64'(fwdA), 64'(vecs[i].expFwdA));
      clockEdge();
      check($sformatf("vec%0d_valid", i), 64'(stValid), 64'(vecs[i].expValid));
      check($sformatf("vec%0d_cnt", i), 64'(stallCnt), 64'(vecs[i].expCnt));
      if (vecs[i].chkPc2)
        check($sformatf("vec%0d_pc2", i), stPc[2*PC_W +: PC_W], vecs[i].expPc2);
      if (vecs[i].chkBubble)
        check($sformatf("vec%0d_bubble_ctrl", i), 64'(stCtrl[0 +: CTRL_W]), 0);
    end

    // Flush with three valid stages. Stages 0 and 1 are squashed and stage 2
    // takes the old stage 1.
    step(1, LD, 64'h40, 10, 20, 21, 0, 0);
    step(1, LD, 64'h44, 11, 20, 21, 0, 0);
    step(1, LD, 64'h48, 12, 20, 21, 0, 0);
    applyStimulus(1, LD, 64'h4C, 13, 12, 21, 0, 1);
    check("flush_no_stall", 64'(stallOut), 0);
    clockEdge();
    check("flush_valid", 64'(stValid), 64'(3'b100));
    check("flush_pc2", stPc[2*PC_W +: PC_W], 64'h44);

    // ext_stall for three cycles, with a hazard in the first and a flush in
    // the second.
    step(1, LD, 64'h50, 13, 20, 21, 0, 0);
    step(1, LD, 64'h54, 14, 20, 21, 0, 0);
    step(1, LD, 64'h58, 15, 20, 21, 0, 0);
    savedCnt = stallCnt;
    applyStimulus(1, ALU, 64'h5C, 16, 15, 21, 1, 0);
    check("ext_haz_stall", 64'(stallOut), 1);
    clockEdge();
    step(1, ALU, 64'h5C, 16, 15, 21, 1, 1);
    check("ext_flush_valid", 64'(stValid), 64'(3'b100));
    check("ext_flush_pc0", stPc[0 +: PC_W], 64'h58);
    step(1, ALU, 64'h5C, 16, 15, 21, 1, 0);
    check("ext_pc1", stPc[PC_W +: PC_W], 64'h54);
    check("ext_cnt", 64'(stallCnt), 64'(savedCnt));
    step(0, '0, 0, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a stream clears everything before the next edge.
    step(1, LD, 64'h60, 16, 20, 21, 0, 0);
    step(1, LD, 64'h64, 17, 20, 21, 0, 0);
    step(1, LD, 64'h68, 18, 20, 21, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    check("midrst_valid", 64'(stValid), 0);
    check("midrst_ctrl", 64'(stCtrl), 0);
    check("midrst_pc", stPc[63:0], 0);
    check("midrst_rd", 64'(stRd), 0);
    check("midrst_cnt", 64'(stallCnt), 0);
    check("midrst_comb", 64'({stallOut, fwdA, fwdB}), 0);
    #1;
    reset = 1'b0;
    step(1, ALU, 64'h70, 10, 20, 21, 0, 0);
    check("post_rst_valid", 64'(stValid), 64'(3'b001));

    // Random traffic over a small register set, so hazards and forwarding
    // cases come up often.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, CTRL_W'($urandom), {$urandom, $urandom},
           REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
           REG_AW'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
